cache_meta_array: RTL and testbench

- Parametrised set-associative cache metadata store: per-set, per-way valid bit and tag, plus per-set true-LRU age state.
- Performs tag lookup with a one-cycle registered response: hit, hit way and replacement victim.
- Accepts fills into a chosen way and runs a sequential invalidate-all sweep.
- Sits beside the cache data array; the cache controller FSM drives it.

---
 rtl/cache_meta_array.sv | 163 ++++++++++++++++
 tb/tb_cache_meta_array.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_meta_array.sv
// Set-associative cache metadata store: per-set valid/tag per way plus
// true-LRU ages, registered lookup response and an invalidate-all sweep.
module cache_meta_array #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 6,
  parameter int WAYS  = 2,
  parameter int AGE_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [IDX_W-1:0] req_index,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAYS-1:0]  rsp_way,
  output logic [WAYS-1:0]  rsp_victim,
  input  logic             fill_valid,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [WAYS-1:0]  fill_way,
  input  logic             inv_all,
  output logic             busy
);
  localparam int SETS = 1 << IDX_W;

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e                               state_q, state_d;
  logic [IDX_W-1:0]                     cnt_q, cnt_d;
  logic [SETS-1:0][WAYS-1:0]            valid_q;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tag_q;
  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age_q;

  logic            rsp_valid_q, rsp_hit_q;
  logic [WAYS-1:0] rsp_way_q, rsp_victim_q;

  logic            idle, req_acc, fill_acc, same_set;
  logic [WAYS-1:0] hit_vec, inval_vec, vic_vec;

  // Touch one way: it becomes youngest, younger ways age by one.
  function automatic logic [WAYS-1:0][AGE_W-1:0] lru_touch(
    input logic [WAYS-1:0][AGE_W-1:0] a,
    input logic [WAYS-1:0]            oh
  );
    logic [AGE_W-1:0]            old;
    logic [WAYS-1:0][AGE_W-1:0]  r;
    old = '0;
    for (int w = 0; w < WAYS; w++)
      if (oh[w]) old = a[w];
    for (int w = 0; w < WAYS; w++) begin
      if (oh[w])          r[w] = '0;
      else if (a[w] < old) r[w] = a[w] + AGE_W'(1);
      else                 r[w] = a[w];
    end
    return r;
  endfunction

  assign idle     = (state_q == IDLE);
  assign req_acc  = req_valid && idle;
  assign fill_acc = fill_valid && idle && $onehot(fill_way);
  assign same_set = (fill_index == req_index);
  assign busy     = (state_q == SWEEP);

  // Tag compare and invalid-way detection on the requested set.
  always_comb begin
    hit_vec   = '0;
    inval_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w]   = valid_q[req_index][w] && (tag_q[req_index][w] == req_tag);
      inval_vec[w] = !valid_q[req_index][w];
    end
  end

  // Victim: lowest invalid way, otherwise the oldest way.
  always_comb begin
    vic_vec = '0;
    if (|inval_vec) begin
      for (int w = WAYS-1; w >= 0; w--)
        if (inval_vec[w]) begin
          vic_vec    = '0;
          vic_vec[w] = 1'b1;
        end
    end else begin
      for (int w = 0; w < WAYS; w++)
        vic_vec[w] = (age_q[req_index][w] == AGE_W'(WAYS-1));
    end
  end

  // Registered lookup response, one cycle after acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_way_q    <= '0;
      rsp_victim_q <= '0;
    end else begin
      rsp_valid_q  <= req_acc;
      rsp_hit_q    <= req_acc && (|hit_vec);
      rsp_way_q    <= req_acc ? hit_vec : '0;
      rsp_victim_q <= req_acc ? vic_vec : '0;
    end
  end

  // Metadata arrays: sweep clears one set per cycle, otherwise hit/fill updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      tag_q   <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= AGE_W'(w);
    end else if (!idle) begin
      valid_q[cnt_q] <= '0;
      for (int w = 0; w < WAYS; w++)
        age_q[cnt_q][w] <= AGE_W'(w);
    end else begin
      // A fill to the same set owns the LRU update this cycle.
      if (req_acc && (|hit_vec) && !(fill_acc && same_set))
        age_q[req_index] <= lru_touch(age_q[req_index], hit_vec);
      if (fill_acc) begin
        valid_q[fill_index] <= valid_q[fill_index] | fill_way;
        for (int w = 0; w < WAYS; w++)
          if (fill_way[w]) tag_q[fill_index][w] <= fill_tag;
        age_q[fill_index] <= lru_touch(age_q[fill_index], fill_way);
      end
    end
  end

  // Sweep FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep FSM next state: walk every set once, then return to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (inv_all) begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
      SWEEP: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(SETS-1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_hit    = rsp_hit_q;
  assign rsp_way    = rsp_way_q;
  assign rsp_victim = rsp_victim_q;

endmodule

// File: tb/tb_cache_meta_array.sv
// Bench for cache_meta_array: a 2-way and a 4-way instance driven by directed
// and random traffic, checked against an abstract set/way/age model.
module tb_cache_meta_array;
  localparam int SETS = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       rv[2], fv[2], inv[2];
  logic [5:0] ri[2], rt[2], fi[2], ft[2];
  logic [3:0] fw[2];

  logic       v2, h2, b2, v4, h4, b4;
  logic [1:0] w2, x2;
  logic [3:0] w4, x4;

  cache_meta_array #(.IDX_W(6), .TAG_W(6), .WAYS(2), .AGE_W(1)) u2 (
    .clk(clk), .rst(rst),
    .req_valid(rv[0]), .req_index(ri[0]), .req_tag(rt[0]),
    .rsp_valid(v2), .rsp_hit(h2), .rsp_way(w2), .rsp_victim(x2),
    .fill_valid(fv[0]), .fill_index(fi[0]), .fill_tag(ft[0]), .fill_way(fw[0][1:0]),
    .inv_all(inv[0]), .busy(b2));

  cache_meta_array #(.IDX_W(6), .TAG_W(6), .WAYS(4), .AGE_W(2)) u4 (
    .clk(clk), .rst(rst),
    .req_valid(rv[1]), .req_index(ri[1]), .req_tag(rt[1]),
    .rsp_valid(v4), .rsp_hit(h4), .rsp_way(w4), .rsp_victim(x4),
    .fill_valid(fv[1]), .fill_index(fi[1]), .fill_tag(ft[1]), .fill_way(fw[1]),
    .inv_all(inv[1]), .busy(b4));

  // Reference model: valid/tag/age per set and way, remaining busy cycles.
  int NW[2] = '{2, 4};
  bit mv[2][SETS][4];
  int mt[2][SETS][4];
  int ma[2][SETS][4];
  int mb[2];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mb[d] = 0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < 4; w++) begin
          mv[d][s][w] = 1'b0;
          mt[d][s][w] = 0;
          ma[d][s][w] = w;
        end
    end
  endtask

  task automatic model_touch(input int d, input int s, input int way);
    int old;
    old = ma[d][s][way];
    for (int w = 0; w < NW[d]; w++)
      if (w == way) ma[d][s][w] = 0;
      else if (ma[d][s][w] < old) ma[d][s][w] = ma[d][s][w] + 1;
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      rv[d] = 0; ri[d] = 0; rt[d] = 0; fv[d] = 0;
      fi[d] = 0; ft[d] = 0; fw[d] = 0; inv[d] = 0;
    end
  endtask

  // One clock of traffic on instance d, then compare against the model.
  task automatic cyc(input int d, input bit rq, input int rix, input int rtg,
                     input bit fl, input int fix, input int ftg, input int fwy,
                     input bit iv);
    int  nw, hw, vw, ob_v, ob_h, ob_w, ob_x, ob_b;
    bit  idle, e_v, f_ok;
    nw = NW[d];
    rv[d] = rq; ri[d] = 6'(rix); rt[d] = 6'(rtg);
    fv[d] = fl; fi[d] = 6'(fix); ft[d] = 6'(ftg); fw[d] = 4'(fwy); inv[d] = iv;

    idle = (mb[d] == 0);
    e_v  = idle && rq;
    hw = -1; vw = -1;
    if (e_v) begin
      for (int w = 0; w < nw; w++)
        if (mv[d][rix][w] && mt[d][rix][w] == rtg) hw = w;
      for (int w = nw-1; w >= 0; w--)
        if (!mv[d][rix][w]) vw = w;
      if (vw < 0)
        for (int w = 0; w < nw; w++)
          if (ma[d][rix][w] == nw-1) vw = w;
    end
    f_ok = idle && fl && $countones(fwy) == 1 && fwy < (1 << nw);
    if (idle) begin
      if (e_v && hw >= 0 && !(f_ok && fix == rix)) model_touch(d, rix, hw);
      if (f_ok)
        for (int w = 0; w < nw; w++)
          if (fwy == (1 << w)) begin
            mv[d][fix][w] = 1'b1;
            mt[d][fix][w] = ftg;
            model_touch(d, fix, w);
          end
      if (iv) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < 4; w++) begin
            mv[d][s][w] = 1'b0;
            ma[d][s][w] = w;
          end
        mb[d] = SETS;
      end
    end else begin
      mb[d] = mb[d] - 1;
    end

    @(posedge clk); #1;
    ob_v = (d == 0) ? int'(v2) : int'(v4);
    ob_h = (d == 0) ? int'(h2) : int'(h4);
    ob_w = (d == 0) ? int'(w2) : int'(w4);
    ob_x = (d == 0) ? int'(x2) : int'(x4);
    ob_b = (d == 0) ? int'(b2) : int'(b4);
    chk("rsp_valid", ob_v, int'(e_v));
    chk("busy", ob_b, int'(mb[d] > 0));
    if (e_v) begin
      chk("rsp_hit", ob_h, int'(hw >= 0));
      chk("rsp_way", ob_w, (hw >= 0) ? (1 << hw) : 0);
      chk("rsp_victim", ob_x, 1 << vw);
    end
    clear_inputs();
  endtask

  task automatic check_reset_outs();
    chk("rst_v2", int'(v2), 0); chk("rst_h2", int'(h2), 0);
    chk("rst_w2", int'(w2), 0); chk("rst_x2", int'(x2), 0);
    chk("rst_b2", int'(b2), 0); chk("rst_v4", int'(v4), 0);
    chk("rst_x4", int'(x4), 0); chk("rst_b4", int'(b4), 0);
  endtask

  task automatic rand_run(input int d, input int n);
    int  rix, rtg, fix, ftg, fwy;
    bit  rq, fl, iv;
    for (int i = 0; i < n; i++) begin
      rq  = ($urandom_range(0, 1) == 1);
      rix = $urandom_range(0, 7);
      rtg = $urandom_range(0, 7);
      fix = ($urandom_range(0, 3) == 0) ? rix : $urandom_range(0, 7);
      ftg = $urandom_range(0, 7);
      fwy = $urandom_range(0, (1 << NW[d]) - 1);
      fl  = ($urandom_range(0, 9) < 4);
      iv  = ($urandom_range(0, 199) == 0);
      // Never create a duplicate tag within a set.
      for (int w = 0; w < NW[d]; w++)
        if (fwy != (1 << w) && mv[d][fix][w] && mt[d][fix][w] == ftg) fl = 1'b0;
      cyc(d, rq, rix, rtg, fl, fix, ftg, fwy, iv);
    end
  endtask

  initial begin
    int nb;
    clear_inputs();
    model_reset();
    #12;
    check_reset_outs();
    @(posedge clk); #1;
    rst = 1'b1;

    // Cold miss, then fill and hit (2-way).
    cyc(0, 1, 5, 'h2A, 0, 0, 0, 0, 0);
    chk("tp1_victim", int'(x2), 1);
    cyc(0, 0, 0, 0, 1, 5, 'h2A, 1, 0);
    cyc(0, 1, 5, 'h2A, 0, 0, 0, 0, 0);
    chk("tp2_way", int'(w2), 1);
    chk("tp2_victim", int'(x2), 2);

    // Same-cycle fill and lookup on one set: lookup sees the old contents.
    cyc(0, 1, 7, 'h11, 1, 7, 'h11, 2, 0);
    chk("tp4_hit0", int'(h2), 0);
    cyc(0, 1, 7, 'h11, 0, 0, 0, 0, 0);
    chk("tp4_way", int'(w2), 2);

    // 4-way LRU ordering.
    for (int w = 0; w < 4; w++) cyc(1, 0, 0, 0, 1, 3, w + 1, 1 << w, 0);
    cyc(1, 1, 3, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 9, 0, 0, 0, 0, 0);
    chk("tp3_victim", int'(x4), 2);

    // Sweep with traffic during busy; count busy cycles.
    for (int s = 0; s < 6; s++) cyc(0, 0, 0, 0, 1, s * 9, s + 3, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    nb = 0;
    for (int k = 0; k < 200 && b2; k++) begin
      nb++;
      cyc(0, 1, k % 64, k % 8, 1, k % 64, 5, 2, (k % 7) == 0);
    end
    chk("sweep_busy_cycles", nb, 64);
    for (int s = 0; s < 6; s++) begin
      cyc(0, 1, s * 9, s + 3, 0, 0, 0, 0, 0);
      chk("post_sweep_miss", int'(h2), 0);
    end

    rand_run(0, 400);
    rand_run(1, 400);

    // Reset in the middle of a sweep.
    while (mb[0] > 0) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 2, 4, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) cyc(0, 1, k, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    check_reset_outs();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(0, 1, 2, 4, 0, 0, 0, 0, 0);
    chk("post_rst_miss", int'(h2), 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("post_rst_inv", int'(b2), 1);
    rand_run(0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
